csa_accum_sequencer: RTL and testbench



---
 rtl/csa_accum_sequencer_pkg.sv | 15 +
 rtl/csa_accum_sequencer_if.sv | 35 +++
 rtl/csa_42_compress.sv | 32 +++
 rtl/csa_accum_sequencer.sv | 126 ++++++++++++
 tb/tb_csa_accum_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/csa_accum_sequencer_pkg.sv
// Shared SFU definitions: accumulator sequencer state encoding and width helper.
package csa_accum_sequencer_pkg;

  typedef enum logic [1:0] {
    SFU_IDLE    = 2'd0,
    SFU_ACCUM   = 2'd1,
    SFU_RESOLVE = 2'd2,
    SFU_OUTPUT  = 2'd3
  } sfu_state_e;

  function automatic int acc_width(input int op_width, input int guard_bits);
    return op_width + guard_bits;
  endfunction

endpackage

// File: rtl/csa_accum_sequencer_if.sv
// Operand stream in, result stream out, for the SFU carry-save accumulator.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the producer holds valid and payload until that edge, and ready never depends on valid.
interface csa_accum_sequencer_if #(
  parameter int OP_WIDTH   = 8,
  parameter int GUARD_BITS = 4,
  parameter int CNT_WIDTH  = 8
);
  import csa_accum_sequencer_pkg::*;
  localparam int ACC_WIDTH = acc_width(OP_WIDTH, GUARD_BITS);

  logic                 in_valid;
  logic                 in_ready;
  logic [OP_WIDTH-1:0]  in_op_a;
  logic [OP_WIDTH-1:0]  in_op_b;
  logic [1:0]           in_mask;
  logic                 in_signed;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_overflow;

  modport master (
    output in_valid, in_op_a, in_op_b, in_mask, in_signed, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_op_a, in_op_b, in_mask, in_signed, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );

endinterface

// File: rtl/csa_42_compress.sv
// 4:2 carry-save compressor built from two full-adder rows; sum + carry == a + b + c + d.
module csa_42_compress #(
  parameter int OP_WIDTH = 12
) (
  input  logic [OP_WIDTH-1:0] a,
  input  logic [OP_WIDTH-1:0] b,
  input  logic [OP_WIDTH-1:0] c,
  input  logic [OP_WIDTH-1:0] d,
  output logic [OP_WIDTH:0]   sum,
  output logic [OP_WIDTH:0]   carry
);

  logic [OP_WIDTH-1:0] maj1;
  logic [OP_WIDTH:0]   t1;
  logic [OP_WIDTH:0]   w1;
  logic [OP_WIDTH:0]   m1;
  logic [OP_WIDTH-1:0] maj2;

  assign t1   = {1'b0, a ^ b ^ c};
  assign maj1 = (a & b) | (a & c) | (b & c);
  assign m1   = {maj1, 1'b0};
  assign w1   = {1'b0, d};

  // Bit OP_WIDTH of t1/w1 is always 0, so the second row never carries out of OP_WIDTH+1 bits.
  assign maj2 = (t1[OP_WIDTH-1:0] & w1[OP_WIDTH-1:0]) |
                (t1[OP_WIDTH-1:0] & m1[OP_WIDTH-1:0]) |
                (w1[OP_WIDTH-1:0] & m1[OP_WIDTH-1:0]);

  assign sum   = t1 ^ w1 ^ m1;
  assign carry = {maj2, 1'b0};

endmodule

// File: rtl/csa_accum_sequencer.sv
// Multi-operand accumulator: folds operand pairs into a carry-save pair, resolves once per packet.
module csa_accum_sequencer
  import csa_accum_sequencer_pkg::*;
#(
  parameter int OP_WIDTH   = 8,
  parameter int GUARD_BITS = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  csa_accum_sequencer_if.slave        bus,
  output logic [1:0]                  dbg_state
);

  localparam int ACC_WIDTH = acc_width(OP_WIDTH, GUARD_BITS);

  localparam logic [1:0] IDLE    = SFU_IDLE;
  localparam logic [1:0] ACCUM   = SFU_ACCUM;
  localparam logic [1:0] RESOLVE = SFU_RESOLVE;
  localparam logic [1:0] OUTPUT  = SFU_OUTPUT;

  localparam logic [CNT_WIDTH:0] OVF_LIMIT = (CNT_WIDTH+1)'(1) << GUARD_BITS;

  logic [1:0]           state;
  logic [ACC_WIDTH-1:0] s_reg;
  logic [ACC_WIDTH-1:0] c_reg;
  logic [CNT_WIDTH-1:0] count;
  logic                 signed_q;
  logic [ACC_WIDTH-1:0] sum_q;
  logic                 ovf_q;
  logic                 valid_q;

  logic                 accepting;
  logic                 beat;
  logic                 eff_signed;
  logic [ACC_WIDTH-1:0] ext_a;
  logic [ACC_WIDTH-1:0] ext_b;
  logic [ACC_WIDTH:0]   cmp_s;
  logic [ACC_WIDTH:0]   cmp_c;
  logic [ACC_WIDTH-1:0] fold_s;
  logic [ACC_WIDTH-1:0] fold_c;
  logic [1:0]           pop;
  logic [CNT_WIDTH:0]   cnt_sum;
  logic [CNT_WIDTH-1:0] count_next;

  assign accepting = (state == IDLE) || (state == ACCUM);
  assign beat      = bus.in_valid && accepting;

  // The signed flag belongs to the packet: the first beat uses the live input, later beats the latch.
  assign eff_signed = (state == IDLE) ? bus.in_signed : signed_q;

  assign ext_a = {{GUARD_BITS{eff_signed & bus.in_op_a[OP_WIDTH-1]}}, bus.in_op_a}
                 & {ACC_WIDTH{bus.in_mask[0]}};
  assign ext_b = {{GUARD_BITS{eff_signed & bus.in_op_b[OP_WIDTH-1]}}, bus.in_op_b}
                 & {ACC_WIDTH{bus.in_mask[1]}};

  csa_42_compress #(.OP_WIDTH(ACC_WIDTH)) u_compress (
    .a     (ext_a),
    .b     (ext_b),
    .c     (s_reg),
    .d     (c_reg),
    .sum   (cmp_s),
    .carry (cmp_c)
  );

  // The total is defined modulo 2^ACC_WIDTH, so the compressor's extra MSB is dropped.
  assign fold_s = cmp_s[ACC_WIDTH-1:0];
  assign fold_c = cmp_c[ACC_WIDTH-1:0];

  logic unused_cmp_msbs;
  assign unused_cmp_msbs = cmp_s[ACC_WIDTH] ^ cmp_c[ACC_WIDTH];

  assign pop        = {1'b0, bus.in_mask[0]} + {1'b0, bus.in_mask[1]};
  assign cnt_sum    = {1'b0, count} + (CNT_WIDTH+1)'(pop);
  assign count_next = cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      s_reg    <= '0;
      c_reg    <= '0;
      count    <= '0;
      signed_q <= 1'b0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (beat) begin
            s_reg <= fold_s;
            c_reg <= fold_c;
            count <= count_next;
            if (state == IDLE) signed_q <= bus.in_signed;
            state <= bus.in_last ? RESOLVE : ACCUM;
          end
        end
        RESOLVE: begin
          sum_q   <= s_reg + c_reg;
          ovf_q   <= ({1'b0, count} > OVF_LIMIT);
          valid_q <= 1'b1;
          state   <= OUTPUT;
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            s_reg   <= '0;
            c_reg   <= '0;
            count   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = accepting;
  assign bus.out_valid    = valid_q;
  assign bus.out_sum      = sum_q;
  assign bus.out_count    = count;
  assign bus.out_overflow = ovf_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Directed bench for csa_accum_sequencer: hand-computed packet totals, latency, backpressure, reset.
module tb_csa_accum_sequencer;

  localparam int OP_WIDTH   = 8;
  localparam int GUARD_BITS = 4;
  localparam int CNT_WIDTH  = 8;
  localparam int ACC_WIDTH  = 12;

  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [ACC_WIDTH-1:0] exp_q[$];

  csa_accum_sequencer_if #(
    .OP_WIDTH(OP_WIDTH), .GUARD_BITS(GUARD_BITS), .CNT_WIDTH(CNT_WIDTH)
  ) bus ();

  csa_accum_sequencer #(
    .OP_WIDTH(OP_WIDTH), .GUARD_BITS(GUARD_BITS), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Driver: one beat, accepted at the next rising edge.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                           input logic sgn, input logic last);
    bus.in_op_a   = a;
    bus.in_op_b   = b;
    bus.in_mask   = m;
    bus.in_signed = sgn;
    bus.in_last   = last;
    bus.in_valid  = 1'b1;
    check_eq("in_ready_on_beat", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Scoreboard: wait (bounded) for a result, compare against the queued total, then handshake.
  task automatic expect_result(input string tag, input int exp_cnt, input int exp_ovf);
    logic [ACC_WIDTH-1:0] exp_sum;
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    exp_sum = exp_q.pop_front();
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_sum"}, 32'(bus.out_sum), 32'(exp_sum));
    check_eq({tag, "_count"}, 32'(bus.out_count), 32'(exp_cnt));
    check_eq({tag, "_overflow"}, 32'(bus.out_overflow), 32'(exp_ovf));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_eq({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [ACC_WIDTH-1:0] held_sum;
    bus.in_valid  = 1'b0;
    bus.in_op_a   = '0;
    bus.in_op_b   = '0;
    bus.in_mask   = 2'b00;
    bus.in_signed = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check_eq("rst_out_count", 32'(bus.out_count), 32'd0);
    check_eq("rst_out_overflow", 32'(bus.out_overflow), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_state", 32'(dbg_state), 32'd0);

    // Single beat: RESOLVE one cycle after acceptance, valid the cycle after that.
    exp_q.push_back(12'd8);
    send_beat(8'd3, 8'd5, 2'b11, 1'b0, 1'b1);
    check_eq("t1_resolve_state", 32'(dbg_state), 32'd2);
    check_eq("t1_resolve_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t1_resolve_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check_eq("t1_latency_valid", 32'(bus.out_valid), 32'd1);
    expect_result("t1", 2, 0);

    // Unsigned max values with a half-masked last beat: 255*5 = 1275.
    exp_q.push_back(12'h4FB);
    send_beat(8'd255, 8'd255, 2'b11, 1'b0, 1'b0);
    send_beat(8'd255, 8'd255, 2'b11, 1'b0, 1'b0);
    send_beat(8'd255, 8'd77, 2'b01, 1'b0, 1'b1);
    expect_result("t2", 5, 0);

    // Signed: -128 + 127 - 1 + 1 = -1; in_signed on the second beat is ignored.
    exp_q.push_back(12'hFFF);
    send_beat(8'h80, 8'h7F, 2'b11, 1'b1, 1'b0);
    send_beat(8'hFF, 8'h01, 2'b11, 1'b0, 1'b1);
    expect_result("t3_signed", 4, 0);

    // Same operands unsigned: 128 + 127 + 255 + 1 = 511.
    exp_q.push_back(12'h1FF);
    send_beat(8'h80, 8'h7F, 2'b11, 1'b0, 1'b0);
    send_beat(8'hFF, 8'h01, 2'b11, 1'b1, 1'b1);
    expect_result("t3_unsigned", 4, 0);

    // Backpressure: result held stable, no input acceptance while waiting.
    exp_q.push_back(12'd30);
    send_beat(8'd10, 8'd20, 2'b11, 1'b0, 1'b1);
    step();
    held_sum = 12'd30;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_sum", 32'(bus.out_sum), 32'(held_sum));
      check_eq("bp_count", 32'(bus.out_count), 32'd2);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    expect_result("bp", 2, 0);

    // Overflow boundary: 16 operands of 255 fit; the 17th wraps and flags.
    exp_q.push_back(12'd4080);
    for (int i = 0; i < 8; i++) send_beat(8'd255, 8'd255, 2'b11, 1'b0, (i == 7));
    expect_result("ovf16", 16, 0);

    exp_q.push_back(12'd239);
    for (int i = 0; i < 8; i++) send_beat(8'd255, 8'd255, 2'b11, 1'b0, 1'b0);
    send_beat(8'd255, 8'd200, 2'b01, 1'b0, 1'b1);
    expect_result("ovf17", 17, 1);

    // Empty-mask beat still ends the packet.
    exp_q.push_back(12'd6);
    send_beat(8'd6, 8'd0, 2'b01, 1'b0, 1'b0);
    send_beat(8'd99, 8'd99, 2'b00, 1'b0, 1'b1);
    expect_result("mask00", 1, 0);

    // Reset mid-packet discards the partial accumulation.
    send_beat(8'd100, 8'd100, 2'b11, 1'b0, 1'b0);
    send_beat(8'd50, 8'd50, 2'b11, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("midrst_count", 32'(bus.out_count), 32'd0);
    exp_q.push_back(12'd16);
    send_beat(8'd7, 8'd9, 2'b11, 1'b0, 1'b1);
    expect_result("postrst", 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
